laser_share_arbiter: RTL

//  Shares one laser output among N requesters (buttons/controllers) with round-robin fairness.

---
 rtl/laser_share_arbiter_if.sv | 16 +
 rtl/laser_share_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/laser_share_arbiter_if.sv
// Handshake bundle between the request stations and the laser share arbiter.
// The master side drives requests and kill; the slave side drives the laser outputs.
interface laser_share_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic         kill;
  logic         x;
  logic [N-1:0] grant;
  logic         busy;
  logic         done;
  logic         aborted;

  modport master (output req, kill, input x, grant, busy, done, aborted);
  modport slave  (input req, kill, output x, grant, busy, done, aborted);
endinterface

// File: rtl/laser_share_arbiter.sv
// Round-robin arbiter sharing one laser output among N requesters.
// Each grant fires for ON_CYCLES, then enforces COOL_CYCLES of off-time.
//
//   state | meaning
//   IDLE  | laser off, picking the next requester from pend | req
//   FIRE  | laser on for the granted requester
//   COOL  | mandatory off-time after a fire (normal or killed)
module laser_share_arbiter #(
  parameter int N           = 4,
  parameter int ON_CYCLES   = 3,
  parameter int COOL_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  laser_share_arbiter_if.slave bus
);

  localparam int MAXC0 = (ON_CYCLES > COOL_CYCLES) ? ON_CYCLES : COOL_CYCLES;
  localparam int MAXC  = (MAXC0 > 2) ? MAXC0 : 2;
  localparam int CW    = $clog2(MAXC);
  localparam int PW    = $clog2(N);

  localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'((COOL_CYCLES > 0) ? COOL_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic [N-1:0]  cand;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   rr_sum;
  logic [PW:0]   ptr_nxt;

  assign cand = pend_q | bus.req;

  // Search starts at ptr_q and wraps modulo N; the extra sum bit absorbs the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int i = 0; i < N; i++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (rr_sum >= (PW+1)'(N)) rr_sum = rr_sum - (PW+1)'(N);
      if (!win_found && cand[rr_sum[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[PW-1:0];
      end
    end
    ptr_nxt = {1'b0, win_idx} + (PW+1)'(1);
    if (ptr_nxt >= (PW+1)'(N)) ptr_nxt = ptr_nxt - (PW+1)'(N);
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | bus.req;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          state_d         = FIRE;
          grant_d         = {{(N-1){1'b0}}, 1'b1} << win_idx;
          ptr_d           = ptr_nxt[PW-1:0];
          cnt_d           = ON_LOAD;
          pend_d[win_idx] = 1'b0;
        end
      end
      FIRE: begin
        if (bus.kill || cnt_q == '0) begin
          grant_d   = '0;
          done_d    = ~bus.kill;
          aborted_d = bus.kill;
          if (COOL_CYCLES > 0) begin
            state_d = COOL;
            cnt_d   = COOL_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COOL: begin
        grant_d = '0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.x       = (state_q == FIRE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;

endmodule
